// File: rtl/dmem_req_queue_pkg.sv
// Shared types and helpers for the data-memory request queue.
package dmem_req_queue_pkg;

  // Lane helpers below are written for a 32-bit bus.
  localparam int unsigned LANE_W = 32;

  // Pipeline access-width codes.
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  // Bus size codes.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bookkeeping for a transaction accepted by the bus but not yet completed.
  typedef struct packed {
    logic       wr;
    logic [1:0] offset;
    logic [1:0] width;
    logic       sign;
  } out_entry_t;

  function automatic logic [1:0] width_to_size(input logic [1:0] width);
    logic [1:0] size;
    case (width)
      W_BYTE:  size = SZ_BYTE;
      W_HALF:  size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    return ((width == W_HALF) && offset[0]) || ((width == W_WORD) && (offset != 2'b00));
  endfunction

  // Place right-justified store data onto its byte lanes; unused lanes are zero.
  function automatic logic [LANE_W-1:0] place_store(input logic [LANE_W-1:0] data,
                                                    input logic [1:0]        offset,
                                                    input logic [1:0]        width);
    logic [LANE_W-1:0] lanes;
    case (width)
      W_BYTE:  lanes = {24'b0, data[7:0]} << {offset, 3'b000};
      W_HALF:  lanes = {16'b0, data[15:0]} << {offset, 3'b000};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Right-justify returned load data and sign/zero extend it.
  function automatic logic [LANE_W-1:0] extract_load(input logic [LANE_W-1:0] rdata,
                                                     input logic [1:0]        offset,
                                                     input logic [1:0]        width,
                                                     input logic              sign);
    logic [LANE_W-1:0] shifted;
    logic [LANE_W-1:0] result;
    shifted = rdata >> {offset, 3'b000};
    case (width)
      W_BYTE:  result = {{24{sign & shifted[7]}}, shifted[7:0]};
      W_HALF:  result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_outstanding_fifo.sv
// Small circular FIFO tracking bus transactions awaiting data_ok.
module dmem_outstanding_fifo #(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned ENTRY_W = 6,
  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  localparam int unsigned CntW = $clog2(MAX_OUT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CntW-1:0]    count_o
);

  logic [ENTRY_W-1:0] mem_q [MAX_OUT];
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUT - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(MAX_OUT));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  // A pop frees the slot a simultaneous push writes, so full+push+pop is legal.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dmem_req_queue.sv
// EX-stage data-memory request generator for an SRAM-like req/addr_ok/data_ok bus.
module dmem_req_queue
  import dmem_req_queue_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,  // must equal LANE_W in this revision
  parameter int unsigned MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        mem_width,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_err,
  output logic              addr_pending,
  output logic              data_pending
);

  localparam int unsigned EntryW = $bits(out_entry_t);
  localparam int unsigned CntW   = $clog2(MAX_OUT + 1);

  // Holding register: the op currently presented on the bus.
  logic              hold_valid_q, hold_valid_d;
  logic              hold_wr_q, hold_wr_d;
  logic [1:0]        hold_size_q, hold_size_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [1:0]        hold_width_q, hold_width_d;
  logic              hold_sign_q, hold_sign_d;

  logic              load_valid_q, load_valid_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              addr_err_q, addr_err_d;

  logic              op_valid, op_misaligned, can_load, capture, accept, pop;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EntryW-1:0] head_bits;
  out_entry_t        head, push_entry;

  assign op_valid      = en & (mem_write | mem_read) & (mem_width != W_NONE);
  assign op_misaligned = is_misaligned(mem_width, phy_addr[1:0]);

  // Registered fullness: a pop this cycle does not free a slot for req.
  assign req           = hold_valid_q & ~fifo_full;
  assign accept        = req & addr_ok;
  assign addr_pending  = hold_valid_q & ~accept;
  assign can_load      = ~hold_valid_q | accept;
  assign capture       = op_valid & ~op_misaligned & can_load;
  assign pop           = data_ok & ~fifo_empty;
  assign data_pending  = (fifo_count != '0);

  assign push_entry = '{wr:     hold_wr_q,
                        offset: hold_addr_q[1:0],
                        width:  hold_width_q,
                        sign:   hold_sign_q};
  assign head       = out_entry_t'(head_bits);

  assign wr         = hold_wr_q;
  assign size       = hold_size_q;
  assign addr       = hold_addr_q;
  assign wdata      = hold_wdata_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign addr_err   = addr_err_q;

  // Holding register next state: release on accept, reload on capture.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_wr_d    = hold_wr_q;
    hold_size_d  = hold_size_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_width_d = hold_width_q;
    hold_sign_d  = hold_sign_q;
    if (accept) begin
      hold_valid_d = 1'b0;
    end
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_wr_d    = mem_write;
      hold_size_d  = width_to_size(mem_width);
      hold_addr_d  = phy_addr;
      hold_wdata_d = mem_write ? place_store(write_data, phy_addr[1:0], mem_width) : '0;
      hold_width_d = mem_width;
      hold_sign_d  = mem_sign;
    end
  end

  // Response path and error pulse next state.
  always_comb begin
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    // A stalled misaligned op is re-presented upstream; report it only when it
    // would otherwise have been consumed.
    addr_err_d   = op_valid & op_misaligned & can_load;
    if (pop && !head.wr) begin
      load_valid_d = 1'b1;
      load_data_d  = extract_load(rdata, head.offset, head.width, head.sign);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_width_q <= '0;
      hold_sign_q  <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_wr_q    <= hold_wr_d;
      hold_size_q  <= hold_size_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_width_q <= hold_width_d;
      hold_sign_q  <= hold_sign_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      addr_err_q   <= addr_err_d;
    end
  end

  dmem_outstanding_fifo #(
    .MAX_OUT (MAX_OUT),
    .ENTRY_W (EntryW)
  ) u_outstanding (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (data_ok),
    .head_o      (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_dmem_req_queue.sv
// Self-checking bench: directed cycle table plus randomized run against a queue model.
module tb_dmem_req_queue;

  localparam int unsigned MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst, en, mem_write, mem_read, mem_sign;
  logic [1:0]  mem_width;
  logic [31:0] phy_addr, write_data;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        load_valid, addr_err, addr_pending, data_pending;
  logic [31:0] load_data;

  dmem_req_queue #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_width    (mem_width),
    .mem_sign     (mem_sign),
    .phy_addr     (phy_addr),
    .write_data   (write_data),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .addr_err     (addr_err),
    .addr_pending (addr_pending),
    .data_pending (data_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic mw, input logic mr,
                       input logic [1:0] w, input logic s, input logic [31:0] a,
                       input logic [31:0] wd, input logic aok, input logic dok,
                       input logic [31:0] rd);
    rst = r; en = e; mem_write = mw; mem_read = mr; mem_width = w; mem_sign = s;
    phy_addr = a; write_data = wd; addr_ok = aok; data_ok = dok; rdata = rd;
  endtask

  // ---------------------------------------------------------------- directed table
  typedef struct {
    string       name;
    logic        rst, en, mw, mr, sign, aok, dok;
    logic [1:0]  width;
    logic [31:0] a, wd, rd;
    logic        e_req, e_ap, e_dp, e_lv, e_ae;
    logic        chk_bus, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic        chk_ld;
    logic [31:0] e_ld;
  } row_t;

  row_t rows[$];
  row_t cur;

  task automatic t_clr();
    cur.name = ""; cur.rst = 0; cur.en = 0; cur.mw = 0; cur.mr = 0; cur.sign = 0;
    cur.aok = 0; cur.dok = 0; cur.width = 0; cur.a = 0; cur.wd = 0; cur.rd = 0;
    cur.e_req = 0; cur.e_ap = 0; cur.e_dp = 0; cur.e_lv = 0; cur.e_ae = 0;
    cur.chk_bus = 0; cur.e_wr = 0; cur.e_size = 0; cur.e_addr = 0; cur.e_wdata = 0;
    cur.chk_ld = 0; cur.e_ld = 0;
  endtask

  task automatic t_op(input logic mw, input logic mr, input logic [1:0] w, input logic s,
                      input logic [31:0] a, input logic [31:0] wd);
    cur.en = 1; cur.mw = mw; cur.mr = mr; cur.width = w; cur.sign = s; cur.a = a; cur.wd = wd;
  endtask

  task automatic t_bus(input logic aok, input logic dok, input logic [31:0] rd);
    cur.aok = aok; cur.dok = dok; cur.rd = rd;
  endtask

  task automatic t_exp(input logic rq, input logic ap, input logic dp, input logic lv,
                       input logic ae);
    cur.e_req = rq; cur.e_ap = ap; cur.e_dp = dp; cur.e_lv = lv; cur.e_ae = ae;
  endtask

  task automatic t_bus_exp(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    cur.chk_bus = 1; cur.e_wr = w; cur.e_size = sz; cur.e_addr = a; cur.e_wdata = wd;
  endtask

  task automatic t_ld(input logic [31:0] v);
    cur.chk_ld = 1; cur.e_ld = v;
  endtask

  task automatic t_row(input string name);
    cur.name = name;
    rows.push_back(cur);
    t_clr();
  endtask

  // Three word loads filling the outstanding queue, third left in hold.
  task automatic t_fill(input string p, input logic [31:0] base);
    t_op(0, 1, 2'b11, 0, base, 0); t_bus(1, 0, 0); t_row({p, "_cap0"});
    t_op(0, 1, 2'b11, 0, base + 4, 0); t_bus(1, 0, 0); t_exp(1, 0, 0, 0, 0);
    t_bus_exp(0, 2'b10, base, 0); t_row({p, "_acc0"});
    t_op(0, 1, 2'b11, 0, base + 8, 0); t_bus(1, 0, 0); t_exp(1, 0, 1, 0, 0);
    t_bus_exp(0, 2'b10, base + 4, 0); t_row({p, "_acc1"});
    t_bus(1, 0, 0); t_exp(0, 1, 1, 0, 0); t_row({p, "_full"});
  endtask

  task automatic build_table();
    t_clr();
    t_bus_exp(0, 0, 0, 0); t_ld(0); t_row("rst_state");
    // Zero-wait word store.
    t_op(1, 0, 2'b11, 0, 32'h1000, 32'hDEADBEEF); t_row("a_cap");
    t_bus(1, 0, 0); t_exp(1, 0, 0, 0, 0); t_bus_exp(1, 2'b10, 32'h1000, 32'hDEADBEEF);
    t_row("a_acc");
    t_bus(0, 1, 0); t_exp(0, 0, 1, 0, 0); t_row("a_dok");
    t_row("a_done");
    // Byte load at offset 3, sign and zero extended.
    for (int s = 1; s >= 0; s--) begin
      t_op(0, 1, 2'b01, s[0], 32'h1003, 0); t_row("b_cap");
      t_bus(1, 0, 0); t_exp(1, 0, 0, 0, 0); t_bus_exp(0, 2'b00, 32'h1003, 0); t_row("b_acc");
      t_bus(0, 1, 32'h80FFFFFF); t_exp(0, 0, 1, 0, 0); t_row("b_dok");
      t_exp(0, 0, 0, 1, 0); t_ld(s ? 32'hFFFFFF80 : 32'h00000080); t_row("b_ld");
    end
    // Half store with the bus stalling for three cycles.
    t_op(1, 0, 2'b10, 0, 32'h2002, 32'h1234ABCD); t_row("c_cap");
    for (int i = 0; i < 3; i++) begin
      t_exp(1, 1, 0, 0, 0); t_bus_exp(1, 2'b01, 32'h2002, 32'hABCD0000); t_row("c_wait");
    end
    t_bus(1, 0, 0); t_exp(1, 0, 0, 0, 0); t_bus_exp(1, 2'b01, 32'h2002, 32'hABCD0000);
    t_row("c_acc");
    t_bus(0, 1, 0); t_exp(0, 0, 1, 0, 0); t_row("c_dok");
    t_row("c_done");
    // Outstanding limit and a single data_ok freeing one slot.
    t_fill("d", 32'h4000);
    t_bus(0, 1, 32'h11111111); t_exp(0, 1, 1, 0, 0); t_row("d_pop0");
    t_bus(1, 0, 0); t_exp(1, 0, 1, 1, 0); t_bus_exp(0, 2'b10, 32'h4008, 0);
    t_ld(32'h11111111); t_row("d_acc2");
    t_bus(0, 1, 32'h22222222); t_exp(0, 0, 1, 0, 0); t_row("d_pop1");
    t_bus(0, 1, 32'h33333333); t_exp(0, 0, 1, 1, 0); t_ld(32'h22222222); t_row("d_pop2");
    t_exp(0, 0, 0, 1, 0); t_ld(32'h33333333); t_row("d_done");
    // Misaligned ops and data_ok on an empty queue.
    t_op(0, 1, 2'b11, 0, 32'h3001, 0); t_row("e_cap");
    t_exp(0, 0, 0, 0, 1); t_row("e_err");
    t_bus(0, 1, 32'hFFFFFFFF); t_row("e_dok_empty");
    t_ld(32'h33333333); t_row("e_no_lv");
    t_op(1, 0, 2'b10, 0, 32'h3003, 32'h5555); t_row("e_hcap");
    t_exp(0, 0, 0, 0, 1); t_row("e_herr");
    t_row("e_clear");
    // Reset with hold valid and two outstanding.
    t_fill("f", 32'h5000);
    cur.rst = 1; t_exp(0, 1, 1, 0, 0); t_row("f_rst");
    t_bus(0, 1, 32'hCAFEF00D); t_bus_exp(0, 0, 0, 0); t_ld(0); t_row("f_dok");
    t_ld(0); t_row("f_after");
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct {
    logic       wr;
    logic [1:0] off;
    logic [1:0] w;
    logic       sgn;
  } ent_t;

  ent_t        mq[$];
  logic        m_hv, m_lv, m_ae;
  ent_t        m_ent;
  logic [31:0] m_addr, m_wdata, m_ld;

  function automatic logic [31:0] ref_place(input logic [31:0] wd, input int off, input int w);
    if (w == 1) return (wd & 32'hFF) << (8 * off);
    if (w == 2) return (wd & 32'hFFFF) << (8 * off);
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int w,
                                           input logic s);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (w == 1) return (s && v[7]) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
    if (w == 2) return (s && v[15]) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hv = 0; m_lv = 0; m_ae = 0; m_ld = 0; m_addr = 0; m_wdata = 0;
    m_ent = '{wr: 0, off: 0, w: 0, sgn: 0};
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    logic        r, e, mw, mr, s, aok, dok, exp_req, acc, opv, mis;
    logic [1:0]  w;
    logic [31:0] a, wd, rd;
    int          off;
    ent_t        popped;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    build_table();

    foreach (rows[i]) begin
      drive(rows[i].rst, rows[i].en, rows[i].mw, rows[i].mr, rows[i].width, rows[i].sign,
            rows[i].a, rows[i].wd, rows[i].aok, rows[i].dok, rows[i].rd);
      @(negedge clk);
      check({rows[i].name, ".req"}, req, rows[i].e_req);
      check({rows[i].name, ".addr_pending"}, addr_pending, rows[i].e_ap);
      check({rows[i].name, ".data_pending"}, data_pending, rows[i].e_dp);
      check({rows[i].name, ".load_valid"}, load_valid, rows[i].e_lv);
      check({rows[i].name, ".addr_err"}, addr_err, rows[i].e_ae);
      if (rows[i].chk_bus) begin
        check({rows[i].name, ".wr"}, wr, rows[i].e_wr);
        check({rows[i].name, ".size"}, size, rows[i].e_size);
        check({rows[i].name, ".addr"}, addr, rows[i].e_addr);
        check({rows[i].name, ".wdata"}, wdata, rows[i].e_wdata);
      end
      if (rows[i].chk_ld) check({rows[i].name, ".load_data"}, load_data, rows[i].e_ld);
      @(posedge clk);
      #1;
    end

    // Randomized run against the queue model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r       = ($urandom_range(0, 149) == 0);
      aok     = ($urandom_range(0, 99) < 60);
      dok     = ($urandom_range(0, 99) < 40);
      rd      = $urandom;
      exp_req = m_hv && (mq.size() < MAX_OUT);
      acc     = exp_req && aok;
      // Upstream is stalled while the held op is not leaving.
      e  = !(m_hv && !acc) && ($urandom_range(0, 3) != 0);
      mw = $urandom_range(0, 1);
      mr = $urandom_range(0, 1);
      w  = 2'($urandom_range(0, 3));
      s  = $urandom_range(0, 1);
      a  = $urandom;
      wd = $urandom;
      drive(r, e, mw, mr, w, s, a, wd, aok, dok, rd);
      @(negedge clk);
      check("rnd.req", req, exp_req);
      check("rnd.addr_pending", addr_pending, m_hv && !acc);
      check("rnd.data_pending", data_pending, mq.size() != 0);
      check("rnd.load_valid", load_valid, m_lv);
      check("rnd.addr_err", addr_err, m_ae);
      check("rnd.load_data", load_data, m_ld);
      if (exp_req) begin
        check("rnd.wr", wr, m_ent.wr);
        check("rnd.size", size, 32'(m_ent.w) - 1);
        check("rnd.addr", addr, m_addr);
        check("rnd.wdata", wdata, m_wdata);
      end
      // Advance the model across the coming clock edge.
      if (r) begin
        model_reset();
      end else begin
        m_lv = 0;
        m_ae = 0;
        if (dok && mq.size() > 0) begin
          popped = mq.pop_front();
          if (!popped.wr) begin
            m_lv = 1;
            m_ld = ref_load(rd, popped.off, popped.w, popped.sgn);
          end
        end
        opv = e && (mw || mr) && (w != 0);
        off = int'(a % 4);
        mis = (w == 2 && off % 2 == 1) || (w == 3 && off != 0);
        if (opv && mis) m_ae = 1;
        if (acc) begin
          mq.push_back(m_ent);
        end
        if (opv && !mis && (!m_hv || acc)) begin
          m_hv    = 1;
          m_ent   = '{wr: mw, off: 2'(off), w: w, sgn: s};
          m_addr  = a;
          m_wdata = mw ? ref_place(wd, off, w) : 32'h0;
        end else if (acc) begin
          m_hv = 0;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_req_queue.md
Name: dmem_req_queue

Overview:
Parametrised successor of the EX-stage data-memory request generator. It accepts one load/store per cycle from the pipeline and drives an SRAM-like req/addr_ok/data_ok bus. It holds each request stable until the bus accepts it, tracks up to MAX_OUT accepted transactions awaiting data_ok, and aligns and sign-extends load data on return. It produces addr_pending and data_pending stall signals for the hazard unit.

Parameters:
ADDR_W, 32, physical address width
DATA_W, 32, bus data width; 32 only in this revision, generic for the 64-bit follow-on
MAX_OUT, 2, max transactions accepted (addr_ok) but not completed (data_ok); power of two, >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  pipeline stage enable; op presented only when 1
mem_write  in  1  store request
mem_read  in  1  load request
mem_width  in  2  00 none, 01 byte, 10 half, 11 word
mem_sign  in  1  load sign-extend (1) or zero-extend (0)
phy_addr  in  ADDR_W  translated address
write_data  in  DATA_W  store data, right-justified
req  out  1  bus request
wr  out  1  1 store, 0 load
size  out  2  00 byte, 01 half, 10 word
addr  out  ADDR_W  bus address
wdata  out  DATA_W  lane-placed store data
addr_ok  in  1  bus accepts req this cycle
data_ok  in  1  oldest outstanding transaction completes this cycle
rdata  in  DATA_W  raw bus read data
load_valid  out  1  registered pulse: load_data valid
load_data  out  DATA_W  aligned, extended load result
addr_err  out  1  registered pulse: misaligned op dropped
addr_pending  out  1  op held, not yet accepted; upstream must stall
data_pending  out  1  at least one outstanding transaction

Behaviour:
- Reset: holding register invalid, FIFO empty. req, wr, load_valid, addr_err, addr_pending, data_pending = 0. size, addr, wdata, load_data = 0.
- Capture: en & (mem_write|mem_read) & mem_width!=00 & (hold empty | hold accepted this cycle) -> latch {wr, size, addr, wdata, offset, width, sign} into hold. mem_write has priority if both are set.
- Store lane placement (offset = addr[1:0]): byte -> data[7:0] at lane offset; half -> data[15:0] at lane offset. All other lanes are zero.
- Misaligned ops are not captured and pulse addr_err the next cycle:
  - half with offset[0]=1
  - word with offset!=0
- req = hold valid & FIFO not full. A pop in the same cycle does not free a slot for req.
- Hold outputs are stable while req=1 and addr_ok=0.
- addr_ok & req: push {wr, offset, width, sign} into FIFO, clear hold (or reload it with a new capture). addr_ok while req=0 is ignored.
- addr_pending = hold valid & ~(req & addr_ok). Combinational.
- data_ok with FIFO non-empty: pop head. If head is a load:
  - shift rdata right by 8*offset
  - extend per width/sign
  - register into load_data; load_valid=1 next cycle
- Store completions pop only; no load_valid.
- data_ok with FIFO empty: ignored, no state change.
- Push and pop in the same cycle are both honoured, including when the FIFO is full. Pointers wrap modulo MAX_OUT.
- data_pending = FIFO count != 0.
- Latency: capture -> req next cycle. Zero-wait bus: addr_ok that cycle, data_ok the following, load_valid one cycle after that.
- en=0 with hold valid: hold persists and the request still completes. en gates capture only.
- rst mid-transaction clears all state. Bus responses arriving after reset are ignored because the FIFO is empty.

Decomposition:
- Shared package holds:
  - width codes (W_NONE/W_BYTE/W_HALF/W_WORD)
  - bus size codes (SZ_BYTE/SZ_HALF/SZ_WORD)
  - the outstanding-entry struct {wr, offset[1:0], width[1:0], sign}
- One sub-module: dmem_outstanding_fifo. Parametrised by MAX_OUT and entry width; push/pop/full/empty/count.
- Lane placement and load extraction are functions in the package.

Test Plan:
- Zero-wait word store, addr 0x1000, data 0xDEADBEEF -> req next cycle with wr=1, size=10, wdata=0xDEADBEEF; data_pending drops after data_ok.
- Byte load at 0x1003, sign=1, rdata 0x80FFFFFF -> load_data=0xFFFFFF80, load_valid one cycle after data_ok. Same op with sign=0 -> 0x00000080.
- Half store at 0x2002, data 0x1234ABCD, addr_ok held low 3 cycles -> wdata=0xABCD0000 stable all cycles, addr_pending=1 for 3 cycles, then 0.
- MAX_OUT=2, three back-to-back loads, no data_ok -> third stays in hold with req=0 and addr_pending=1. A single data_ok frees a slot and req asserts next cycle.
- Word load at 0x3001 -> no req, addr_err=1 one cycle. data_ok with FIFO empty -> no load_valid, state unchanged.
- rst asserted while hold valid and 2 outstanding -> next cycle req=0, data_pending=0; a subsequent data_ok produces no load_valid.
